seq_muldiv_alu: RTL and testbench

- Parametrised, clocked successor of the combinational ALU.
- Keeps the existing 4-bit ALU control encoding for the single-cycle ops and adds RV32M-style multiply, divide and remainder.
- Multiply and divide run iteratively over WIDTH cycles behind a start/busy/done handshake.
- Sits in the execute stage of the multicycle datapath. The control FSM pulses start and waits on done.

---
 rtl/seq_muldiv_alu.sv | 233 +++++++++++++++++++++++
 tb/tb_seq_muldiv_alu.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_muldiv_alu.sv
// Sequential ALU for the execute stage of the multicycle datapath.
// Logic, add/sub, compare and shift ops finish in one cycle. Multiply,
// divide and remainder reuse one shift register pair over WIDTH cycles,
// behind a start/busy/done handshake.
module seq_muldiv_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULH  = 4'b1001;
  localparam logic [3:0] OP_MULHU = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;
  localparam logic [3:0] OP_DIV   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_REM   = 4'b1111;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Two's-complement negate when neg is set (magnitude / sign restore).
  function automatic logic [WIDTH-1:0] f_neg_if(input logic neg, input logic [WIDTH-1:0] v);
    f_neg_if = neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg2_if(input logic neg, input logic [2*WIDTH-1:0] v);
    f_neg2_if = neg ? -v : v;
  endfunction

  // Single-cycle op group; unlisted codes fall back to ADD.
  function automatic logic [WIDTH-1:0] f_alu(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [SHW-1:0]          sh;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    case (op)
      OP_AND:  f_alu = a & b;
      OP_OR:   f_alu = a | b;
      OP_XOR:  f_alu = a ^ b;
      OP_SUB:  f_alu = a - b;
      OP_SLT:  f_alu = (sa < sb) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      OP_SLL:  f_alu = a << sh;
      OP_SRL:  f_alu = a >> sh;
      OP_SRA:  f_alu = $unsigned(sa >>> sh);
      default: f_alu = a + b;
    endcase
  endfunction

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz_pend;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_dbz;

  logic               w_accept;
  logic               w_multi;
  logic               w_sgn;
  logic               w_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_b_zero;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_alu;
  logic               w_calc_mul;
  logic [WIDTH:0]     w_madd;
  logic [WIDTH:0]     w_dshift;
  logic               w_dge;
  logic [WIDTH-1:0]   w_dsub;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_res;

  // Issue decode, one iteration step, and final sign/half selection.
  always_comb begin
    w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_multi  = control[3] && (control != OP_SRA);
    w_sgn    = (control == OP_MULH) || (control == OP_DIV) || (control == OP_REM);
    w_div    = (control == OP_DIV) || (control == OP_DIVU) ||
               (control == OP_REM) || (control == OP_REMU);
    w_a_neg  = w_sgn && A[WIDTH-1];
    w_b_neg  = w_sgn && B[WIDTH-1];
    w_a_mag  = f_neg_if(w_a_neg, A);
    w_b_mag  = f_neg_if(w_b_neg, B);
    w_b_zero = (B == '0);
    w_ovf    = w_sgn && w_div && (A == MIN_NEG) && (B == '1);
    w_alu    = f_alu(control, A, B);

    w_calc_mul = (r_op == OP_MUL) || (r_op == OP_MULH) || (r_op == OP_MULHU);
    // Shift-add: r_lo holds the multiplier, product shifts in from the top.
    w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    // Restoring divide: r_hi is the partial remainder, r_lo dividend/quotient.
    w_dshift = {r_hi, r_lo[WIDTH-1]};
    w_dge    = (w_dshift >= {1'b0, r_b});
    w_dsub   = w_dshift[WIDTH-1:0] - r_b;

    w_prod = f_neg2_if(r_neg_q, {r_hi, r_lo});
    w_quo  = f_neg_if(r_neg_q, r_lo);
    w_rem  = f_neg_if(r_neg_r, r_hi);
    case (r_op)
      OP_MUL:            w_fix_res = w_prod[WIDTH-1:0];
      OP_MULH, OP_MULHU: w_fix_res = w_prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:   w_fix_res = w_quo;
      default:           w_fix_res = w_rem;
    endcase
  end

  // Control FSM and iterative datapath; outputs only move on the done-producing edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_b        <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_dbz      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_op <= control;
            if (!w_multi) begin
              r_result <= w_alu;
              r_zero   <= (w_alu == '0);
              r_dbz    <= 1'b0;
              r_state  <= S_DONE;
            end else if (w_div && w_b_zero) begin
              r_hi       <= A;
              r_lo       <= '1;
              r_neg_q    <= 1'b0;
              r_neg_r    <= 1'b0;
              r_dbz_pend <= 1'b1;
              r_cnt      <= '0;
              r_state    <= S_FIX;
            end else if (w_ovf) begin
              r_hi       <= '0;
              r_lo       <= A;
              r_neg_q    <= 1'b0;
              r_neg_r    <= 1'b0;
              r_dbz_pend <= 1'b0;
              r_cnt      <= '0;
              r_state    <= S_FIX;
            end else begin
              r_hi       <= '0;
              r_lo       <= w_a_mag;
              r_b        <= w_b_mag;
              r_neg_q    <= w_a_neg ^ w_b_neg;
              r_neg_r    <= w_a_neg;
              r_dbz_pend <= 1'b0;
              r_cnt      <= CNT_W'(WIDTH);
              r_state    <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (w_calc_mul) begin
            r_hi <= w_madd[WIDTH:1];
            r_lo <= {w_madd[0], r_lo[WIDTH-1:1]};
          end else if (w_dge) begin
            r_hi <= w_dsub;
            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
          end else begin
            r_hi <= w_dshift[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_zero   <= (w_fix_res == '0);
          r_dbz    <= r_dbz_pend;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == S_CALC) || (r_state == S_FIX);
  assign done        = (r_state == S_DONE);
  assign result      = r_result;
  assign zero        = r_zero;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_muldiv_alu.sv
// Self-checking bench for seq_muldiv_alu (WIDTH=32): directed vectors,
// randomized ops against an arithmetic reference model, handshake and abort.
module tb_seq_muldiv_alu;

  localparam int W = 32;

  localparam logic [3:0] C_AND   = 4'b0000;
  localparam logic [3:0] C_OR    = 4'b0001;
  localparam logic [3:0] C_ADD   = 4'b0010;
  localparam logic [3:0] C_XOR   = 4'b0011;
  localparam logic [3:0] C_SLL   = 4'b0100;
  localparam logic [3:0] C_SRL   = 4'b0101;
  localparam logic [3:0] C_SUB   = 4'b0110;
  localparam logic [3:0] C_SLT   = 4'b0111;
  localparam logic [3:0] C_MUL   = 4'b1000;
  localparam logic [3:0] C_MULH  = 4'b1001;
  localparam logic [3:0] C_MULHU = 4'b1010;
  localparam logic [3:0] C_REMU  = 4'b1011;
  localparam logic [3:0] C_DIV   = 4'b1100;
  localparam logic [3:0] C_SRA   = 4'b1101;
  localparam logic [3:0] C_DIVU  = 4'b1110;
  localparam logic [3:0] C_REM   = 4'b1111;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        d;
    int          lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   ctl = 4'd0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         dbz;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_muldiv_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .control(ctl), .A(opa), .B(opb),
    .busy(busy), .done(done), .result(result), .zero(zero), .div_by_zero(dbz)
  );

  // Reference behaviour from the arithmetic definition of each op.
  function automatic void ref_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic d, output int lat);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [63:0] sp;
    logic [63:0]        up;
    sa = a;
    sb = b;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    up = {32'd0, a} * {32'd0, b};
    sp = sa64 * sb64;
    d = 1'b0;
    lat = 1;
    r = a + b;
    case (c)
      C_AND: r = a & b;
      C_OR:  r = a | b;
      C_XOR: r = a ^ b;
      C_SUB: r = a - b;
      C_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
      C_SLL: r = a << b[4:0];
      C_SRL: r = a >> b[4:0];
      C_SRA: r = sa >>> b[4:0];
      C_MUL:   begin r = up[31:0];  lat = 34; end
      C_MULH:  begin r = sp[63:32]; lat = 34; end
      C_MULHU: begin r = up[63:32]; lat = 34; end
      C_DIV, C_REM: begin
        if (b == 32'd0) begin
          r = (c == C_DIV) ? 32'hFFFF_FFFF : a; d = 1'b1; lat = 2;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = (c == C_DIV) ? a : 32'd0; lat = 2;
        end else begin
          r = (c == C_DIV) ? sa / sb : sa % sb; lat = 34;
        end
      end
      C_DIVU, C_REMU: begin
        if (b == 32'd0) begin
          r = (c == C_DIVU) ? 32'hFFFF_FFFF : a; d = 1'b1; lat = 2;
        end else begin
          r = (c == C_DIVU) ? a / b : a % b; lat = 34;
        end
      end
      default: r = a + b;
    endcase
  endfunction

  // Issue one op at a falling edge and wait (bounded) for done; cyc counts cycles to done.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output logic d, output int cyc);
    ctl = c; opa = a; opb = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    r = result; z = zero; d = dbz;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    ctl = C_ADD; opa = 32'd5; opb = 32'd7; start = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
    checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", dbz); end
    start = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle done=%b busy=%b exp 0/0", done, busy);
    end
    checks++; if (result !== 32'd0 || zero !== 1'b1) begin
      failures++; $display("FAIL post_reset_hold result=%h zero=%b exp 0/1", result, zero);
    end
  endtask

  task automatic test_single();
    vec_t tbl [9] = '{
      '{C_SUB, 32'd2000, 32'd2000, 32'd0, 1'b0, 1},
      '{C_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1},
      '{C_AND, 32'd31, 32'd21, 32'd21, 1'b0, 1},
      '{C_OR,  32'd21, 32'd8, 32'd29, 1'b0, 1},
      '{C_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1},
      '{C_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1},
      '{C_SLL, 32'd1, 32'd33, 32'd2, 1'b0, 1},
      '{C_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1},
      '{C_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1}
    };
    logic [31:0] r;
    logic z, d;
    int cyc;
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].c, tbl[i].a, tbl[i].b, r, z, d, cyc);
      checks++; if (r !== tbl[i].r) begin failures++; $display("FAIL single[%0d] result got=%h exp=%h", i, r, tbl[i].r); end
      checks++; if (z !== (tbl[i].r == 32'd0)) begin failures++; $display("FAIL single[%0d] zero got=%b", i, z); end
      checks++; if (cyc != tbl[i].lat) begin failures++; $display("FAIL single[%0d] latency got=%0d exp=%0d", i, cyc, tbl[i].lat); end
    end
  endtask

  task automatic test_muldiv();
    vec_t tbl [7] = '{
      '{C_MUL,   32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 34},
      '{C_MULH,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 1'b0, 34},
      '{C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34},
      '{C_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34},
      '{C_REM,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34},
      '{C_DIVU,  32'd100, 32'd7, 32'd14, 1'b0, 34},
      '{C_REMU,  32'd100, 32'd7, 32'd2, 1'b0, 34}
    };
    logic [31:0] r;
    logic z, d;
    int cyc;
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].c, tbl[i].a, tbl[i].b, r, z, d, cyc);
      checks++; if (r !== tbl[i].r) begin failures++; $display("FAIL muldiv[%0d] result got=%h exp=%h", i, r, tbl[i].r); end
      checks++; if (d !== tbl[i].d) begin failures++; $display("FAIL muldiv[%0d] div_by_zero got=%b exp=%b", i, d, tbl[i].d); end
      checks++; if (cyc != tbl[i].lat) begin failures++; $display("FAIL muldiv[%0d] latency got=%0d exp=%0d", i, cyc, tbl[i].lat); end
    end
  endtask

  task automatic test_div_edge();
    vec_t tbl [6] = '{
      '{C_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 2},
      '{C_REM,  32'd5, 32'd0, 32'd5, 1'b1, 2},
      '{C_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 2},
      '{C_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 2},
      '{C_DIV,  32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 1'b1, 2},
      '{C_REMU, 32'd9, 32'd0, 32'd9, 1'b1, 2}
    };
    logic [31:0] r;
    logic z, d;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].c, tbl[i].a, tbl[i].b, r, z, d, cyc);
      checks++; if (r !== tbl[i].r) begin failures++; $display("FAIL div_edge[%0d] result got=%h exp=%h", i, r, tbl[i].r); end
      checks++; if (z !== (tbl[i].r == 32'd0)) begin failures++; $display("FAIL div_edge[%0d] zero got=%b", i, z); end
      checks++; if (d !== tbl[i].d) begin failures++; $display("FAIL div_edge[%0d] div_by_zero got=%b exp=%b", i, d, tbl[i].d); end
      checks++; if (cyc != tbl[i].lat) begin failures++; $display("FAIL div_edge[%0d] latency got=%0d exp=%0d", i, cyc, tbl[i].lat); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, er;
    logic [3:0] c;
    logic z, d, ed;
    int cyc, elat, mode;
    for (int i = 0; i < 60; i++) begin
      c = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      mode = $urandom_range(0, 3);
      b = (mode == 0) ? 32'd0 : (mode == 1) ? $urandom_range(1, 9) :
          (mode == 2) ? 32'hFFFF_FFFF : $urandom;
      ref_model(c, a, b, er, ed, elat);
      run_op(c, a, b, r, z, d, cyc);
      checks++; if (r !== er) begin failures++; $display("FAIL random[%0d] op=%b a=%h b=%h result got=%h exp=%h", i, c, a, b, r, er); end
      checks++; if (z !== (er == 32'd0)) begin failures++; $display("FAIL random[%0d] zero got=%b", i, z); end
      checks++; if (d !== ed) begin failures++; $display("FAIL random[%0d] div_by_zero got=%b exp=%b", i, d, ed); end
      checks++; if (cyc != elat) begin failures++; $display("FAIL random[%0d] op=%b latency got=%0d exp=%0d", i, c, cyc, elat); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] r;
    logic z, d;
    int cyc;
    run_op(C_ADD, 32'd10, 32'd20, r, z, d, cyc);
    @(negedge clk);
    ctl = C_MUL; opa = 32'hFFFF_FFFD; opb = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    repeat (3) begin @(negedge clk); cyc++; end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ignore_busy got=%b exp=1", busy); end
    checks++; if (result !== 32'd30) begin failures++; $display("FAIL ignore_hold_result got=%h exp=%h", result, 32'd30); end
    ctl = C_ADD; opa = 32'd1; opb = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc++;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (result !== 32'hFFFF_FFEB) begin failures++; $display("FAIL ignore_result got=%h exp=FFFFFFEB", result); end
    checks++; if (cyc != 34) begin failures++; $display("FAIL ignore_latency got=%0d exp=34", cyc); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL done_pulse_width done=%b busy=%b exp 0/0", done, busy);
    end
    checks++; if (result !== 32'hFFFF_FFEB) begin failures++; $display("FAIL result_held got=%h exp=FFFFFFEB", result); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic z, d;
    int cyc;
    @(negedge clk);
    run_op(C_ADD, 32'd5, 32'd6, r, z, d, cyc);
    checks++; if (r !== 32'd11) begin failures++; $display("FAIL b2b_add got=%h exp=%h", r, 32'd11); end
    run_op(C_MUL, 32'h0001_0000, 32'h0001_0000, r, z, d, cyc);
    checks++; if (r !== 32'd0 || z !== 1'b1) begin failures++; $display("FAIL b2b_mul result=%h zero=%b exp 0/1", r, z); end
    checks++; if (cyc != 34) begin failures++; $display("FAIL b2b_mul_latency got=%0d exp=34", cyc); end
    run_op(C_SUB, 32'd3, 32'd5, r, z, d, cyc);
    checks++; if (r !== 32'hFFFF_FFFE || cyc != 1) begin
      failures++; $display("FAIL b2b_sub result=%h lat=%0d exp FFFFFFFE/1", r, cyc);
    end
    run_op(C_MULHU, 32'h0001_0000, 32'h0001_0000, r, z, d, cyc);
    checks++; if (r !== 32'd1 || cyc != 34) begin
      failures++; $display("FAIL b2b_mulhu result=%h lat=%0d exp 1/34", r, cyc);
    end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    logic z, d;
    int cyc;
    logic saw_done;
    @(negedge clk);
    ctl = C_DIVU; opa = 32'd1000; opb = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL abort_async busy=%b done=%b exp 0/0", busy, done);
    end
    checks++; if (result !== 32'd0 || zero !== 1'b1 || dbz !== 1'b0) begin
      failures++; $display("FAIL abort_outputs result=%h zero=%b dbz=%b exp 0/1/0", result, zero, dbz);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", saw_done); end
    run_op(C_DIVU, 32'd1000, 32'd3, r, z, d, cyc);
    checks++; if (r !== 32'd333 || cyc != 34) begin
      failures++; $display("FAIL after_abort result=%h lat=%0d exp %h/34", r, cyc, 32'd333);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_muldiv();
    test_div_edge();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
